// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared flag type and stage-count helper for pipelined_divider_hs
package divider_pkg;

    // Per-op sideband flags; neg_q/neg_r only ever set when DIVIDER_SIGNED_EN is defined.
    typedef struct packed {
        logic neg_q;
        logic neg_r;
        logic dbz;
        logic ovf;
    } div_flags_t;

    function automatic int stage_count(input int data_width, input int frac_bits);
        return data_width + frac_bits;
    endfunction

endpackage

// File: rtl/divider_hs_slot.sv
// rtl/divider_hs_slot.sv - valid/ready register slot, pure wiring when REGISTERED=0
module divider_hs_slot #(
    parameter int WIDTH      = 8,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    generate
        if (REGISTERED) begin : g_reg
            logic             valid_q;
            logic [WIDTH-1:0] data_q;

            // An empty slot always accepts, which is what collapses bubbles.
            assign in_ready  = !valid_q || out_ready;
            assign out_valid = valid_q;
            assign out_data  = data_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else if (in_ready) begin
                    valid_q <= in_valid;
                    if (in_valid) begin
                        data_q <= in_data;
                    end
                end
            end
        end else begin : g_bypass
            assign in_ready  = out_ready;
            assign out_valid = in_valid;
            assign out_data  = in_data;

            logic unused_bypass;
            assign unused_bypass = clk ^ rst;
        end
    endgenerate

endmodule

// File: rtl/divider_iter_comb.sv
// rtl/divider_iter_comb.sv - one combinational restoring-division iteration
module divider_iter_comb #(
    parameter int DATAWIDTH = 8,
    parameter int QWIDTH    = 8
) (
    input  logic [DATAWIDTH-1:0] rem_in,
    input  logic [QWIDTH-1:0]    quo_in,
    input  logic                 dividend_bit,
    input  logic [DATAWIDTH-1:0] divisor,
    output logic [DATAWIDTH-1:0] rem_out,
    output logic [QWIDTH-1:0]    quo_out
);
    logic [DATAWIDTH:0] trial;
    logic [DATAWIDTH:0] diff;
    logic               ge;

    // Both branches fit DATAWIDTH bits: the kept remainder is always below the divisor.
    always_comb begin
        trial   = {rem_in, dividend_bit};
        diff    = trial - {1'b0, divisor};
        ge      = (trial >= {1'b0, divisor});
        rem_out = ge ? diff[DATAWIDTH-1:0] : trial[DATAWIDTH-1:0];
        quo_out = (quo_in << 1) | QWIDTH'(ge);
    end

    logic unused_diff_msb;
    assign unused_diff_msb = diff[DATAWIDTH];

endmodule

// File: rtl/pipelined_divider_hs.sv
// rtl/pipelined_divider_hs.sv - restoring array divider with valid/ready backpressure
// Optional two's-complement mode is built only when DIVIDER_SIGNED_EN is defined.
module pipelined_divider_hs
    import divider_pkg::*;
#(
    parameter int                           DATAWIDTH = 8,
    parameter int                           FRAC_BITS = 0,
    parameter int                           ID_WIDTH  = 4,
    parameter logic [DATAWIDTH+FRAC_BITS:0] PIPE_MASK = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic                 i_signed,
    input  logic [ID_WIDTH-1:0]  i_id,
    input  logic [DATAWIDTH-1:0] A,
    input  logic [DATAWIDTH-1:0] B,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [ID_WIDTH-1:0]  o_id,
    output logic [DATAWIDTH-1:0] Q_out,
    output logic [DATAWIDTH-1:0] R_out,
    output logic                 o_dbz,
    output logic                 o_ovf
);
    localparam int N = stage_count(DATAWIDTH, FRAC_BITS);

    typedef struct packed {
        logic [ID_WIDTH-1:0]  id;
        div_flags_t           flags;
        logic [DATAWIDTH-1:0] rem;
        logic [N-1:0]         quo;
        logic [N-1:0]         dividend;
        logic [DATAWIDTH-1:0] divisor;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

    // Final boundary reuses the payload: quo[DATAWIDTH-1:0]=Q, rem=R, flags.dbz/ovf final.
    function automatic slot_t finish_op(input slot_t s);
        slot_t                f;
        logic [N:0]           q_hi;
        logic [DATAWIDTH-1:0] q;
        logic [DATAWIDTH-1:0] r;
        q_hi = {1'b0, s.quo} >> DATAWIDTH;
        q    = s.quo[DATAWIDTH-1:0];
        r    = s.flags.dbz ? s.dividend[N-1 -: DATAWIDTH] : s.rem;
`ifdef DIVIDER_SIGNED_EN
        if (s.flags.neg_q) q = -q;
        if (s.flags.neg_r) r = -r;
`endif
        f                       = '0;
        f.id                    = s.id;
        f.flags.dbz             = s.flags.dbz;
        f.flags.ovf             = !s.flags.dbz && ((|q_hi) || s.flags.ovf);
        f.quo[DATAWIDTH-1:0]    = s.flags.dbz ? {DATAWIDTH{1'b1}} : q;
        f.rem                   = r;
        return f;
    endfunction

    slot_t head_d;

`ifdef DIVIDER_SIGNED_EN
    logic                 sign_a;
    logic                 sign_b;
    logic [DATAWIDTH-1:0] mag_a;
    logic [DATAWIDTH-1:0] mag_b;

    // Divide magnitudes; sign corrections ride along in the flags to the last boundary.
    always_comb begin
        sign_a              = i_signed & A[DATAWIDTH-1];
        sign_b              = i_signed & B[DATAWIDTH-1];
        mag_a               = sign_a ? -A : A;
        mag_b               = sign_b ? -B : B;
        head_d              = '0;
        head_d.id           = i_id;
        head_d.flags.neg_q  = sign_a ^ sign_b;
        head_d.flags.neg_r  = sign_a;
        head_d.flags.dbz    = (B == '0);
        head_d.flags.ovf    = i_signed && (A == {1'b1, {(DATAWIDTH-1){1'b0}}}) && (&B);
        head_d.dividend     = N'(mag_a) << FRAC_BITS;
        head_d.divisor      = mag_b;
    end
`else
    always_comb begin
        head_d           = '0;
        head_d.id        = i_id;
        head_d.flags.dbz = (B == '0);
        head_d.dividend  = N'(A) << FRAC_BITS;
        head_d.divisor   = B;
    end

    logic unused_signed;
    assign unused_signed = i_signed;
`endif

    // Boundary k sits in front of iteration k; boundary N follows the last iteration.
    for (genvar k = 0; k <= N; k++) begin : g_slot
        logic  in_valid;
        logic  in_ready;
        logic  out_valid;
        logic  out_ready;
        slot_t in_d;
        slot_t out_d;

        if (k == 0) begin : g_head
            assign in_valid = i_valid;
            assign in_d     = head_d;
        end else begin : g_body
            logic [DATAWIDTH-1:0] it_rem;
            logic [N-1:0]         it_quo;
            slot_t                stepped;

            divider_iter_comb #(
                .DATAWIDTH (DATAWIDTH),
                .QWIDTH    (N)
            ) u_iter (
                .rem_in       (g_slot[k-1].out_d.rem),
                .quo_in       (g_slot[k-1].out_d.quo),
                .dividend_bit (g_slot[k-1].out_d.dividend[N-k]),
                .divisor      (g_slot[k-1].out_d.divisor),
                .rem_out      (it_rem),
                .quo_out      (it_quo)
            );

            always_comb begin
                stepped     = g_slot[k-1].out_d;
                stepped.rem = it_rem;
                stepped.quo = it_quo;
            end

            assign in_valid = g_slot[k-1].out_valid;

            if (k == N) begin : g_tail
                assign in_d = finish_op(stepped);
            end else begin : g_mid
                assign in_d = stepped;
            end
        end

        if (k == N) begin : g_out
            assign out_ready = o_ready;
        end else begin : g_link
            assign out_ready = g_slot[k+1].in_ready;
        end

        divider_hs_slot #(
            .WIDTH      (SLOT_W),
            .REGISTERED (PIPE_MASK[k])
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_d),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_d)
        );
    end

    assign i_ready = g_slot[0].in_ready;
    assign o_valid = g_slot[N].out_valid;
    assign o_id    = g_slot[N].out_d.id;
    assign Q_out   = g_slot[N].out_d.quo[DATAWIDTH-1:0];
    assign R_out   = g_slot[N].out_d.rem;
    assign o_dbz   = g_slot[N].out_d.flags.dbz;
    assign o_ovf   = g_slot[N].out_d.flags.ovf;

    logic unused_tail;
    assign unused_tail = ^{g_slot[N].out_d.quo, g_slot[N].out_d.dividend,
                           g_slot[N].out_d.divisor, g_slot[N].out_d.flags.neg_q,
                           g_slot[N].out_d.flags.neg_r};

endmodule

// File: tb/tb_pipelined_divider_hs.sv
// tb/tb_pipelined_divider_hs.sv - directed and streaming checks for pipelined_divider_hs
module tb_pipelined_divider_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       sgn;
    logic [3:0] id_in;
    logic       o_ready;
    logic [2:0] iv;
    logic [2:0] ir;
    logic [2:0] ov;
    logic [2:0] dbz;
    logic [2:0] ovf;
    logic [3:0] oid [3];
    logic [7:0] q   [3];
    logic [7:0] r   [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 0: default, all boundaries registered
    pipelined_divider_hs #(.DATAWIDTH(8), .FRAC_BITS(0), .ID_WIDTH(4), .PIPE_MASK(9'h1FF)) dut_a (
        .clk(clk), .rst(rst), .i_valid(iv[0]), .i_ready(ir[0]), .i_signed(sgn), .i_id(id_in),
        .A(a_in), .B(b_in), .o_valid(ov[0]), .o_ready(o_ready), .o_id(oid[0]),
        .Q_out(q[0]), .R_out(r[0]), .o_dbz(dbz[0]), .o_ovf(ovf[0]));

    // 1: eight fractional bits, alternating boundaries (9 registered of 17)
    pipelined_divider_hs #(.DATAWIDTH(8), .FRAC_BITS(8), .ID_WIDTH(4), .PIPE_MASK(17'h15555)) dut_b (
        .clk(clk), .rst(rst), .i_valid(iv[1]), .i_ready(ir[1]), .i_signed(sgn), .i_id(id_in),
        .A(a_in), .B(b_in), .o_valid(ov[1]), .o_ready(o_ready), .o_id(oid[1]),
        .Q_out(q[1]), .R_out(r[1]), .o_dbz(dbz[1]), .o_ovf(ovf[1]));

    // 2: fully combinational
    pipelined_divider_hs #(.DATAWIDTH(8), .FRAC_BITS(0), .ID_WIDTH(4), .PIPE_MASK(9'h000)) dut_c (
        .clk(clk), .rst(rst), .i_valid(iv[2]), .i_ready(ir[2]), .i_signed(sgn), .i_id(id_in),
        .A(a_in), .B(b_in), .o_valid(ov[2]), .o_ready(o_ready), .o_id(oid[2]),
        .Q_out(q[2]), .R_out(r[2]), .o_dbz(dbz[2]), .o_ovf(ovf[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural reference for 8-bit operands, no fraction: returns {dbz, ovf, q, r}.
    function automatic logic [17:0] ref_div(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ia;
        int ib;
        int qq;
        int rr;
        if (b == 8'd0) return {1'b1, 1'b0, 8'hFF, a};
`ifdef DIVIDER_SIGNED_EN
        if (s) begin
            ia = $signed(a);
            ib = $signed(b);
            if (ia == -128 && ib == -1) return {1'b0, 1'b1, 8'h80, 8'h00};
            qq = ia / ib;
            rr = ia % ib;
            return {1'b0, 1'b0, qq[7:0], rr[7:0]};
        end
`else
        if (s) begin
            ia = 0;
        end
`endif
        ia = int'(a);
        ib = int'(b);
        qq = ia / ib;
        rr = ia % ib;
        return {1'b0, 1'b0, qq[7:0], rr[7:0]};
    endfunction

    task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [3:0] id, input int exp_lat, input logic [17:0] exp,
                          input string tag);
        int lat;
        @(negedge clk);
        a_in    = a;
        b_in    = b;
        sgn     = s;
        id_in   = id;
        o_ready = 1'b1;
        iv[sel] = 1'b1;
        #1;
        check_eq({tag, "_irdy"}, ir[sel], 1);
        lat = 0;
        while (!ov[sel] && lat < 40) begin
            @(negedge clk);
            iv[sel] = 1'b0;
            lat++;
            #1;
        end
        iv[sel] = 1'b0;
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_res"}, {dbz[sel], ovf[sel], q[sel], r[sel]}, exp);
        check_eq({tag, "_id"}, oid[sel], id);
    endtask

    initial begin
        logic [21:0] exp_q [$];
        logic [21:0] cur;
        logic [21:0] prev_out;
        logic        prev_ov;
        logic        prev_ordy;
        logic        acc;
        int          sent;
        int          got;
        int          seen;

        rst = 1'b1; iv = '0; o_ready = 1'b0; sgn = 1'b0;
        a_in = '0; b_in = '0; id_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_ovalid", ov[0], 0);
        check_eq("rst_iready", ir[0], 1);
        check_eq("rst_data", {oid[0], q[0], r[0], dbz[0], ovf[0]}, 0);

        run_op(0, 8'd100, 8'd7,  1'b0, 4'd1, 9, {2'b00, 8'd14, 8'd2}, "a_100_7");
        run_op(0, 8'h5A,  8'd0,  1'b0, 4'd2, 9, {2'b10, 8'hFF, 8'h5A}, "a_dbz");
        run_op(0, 8'd255, 8'd1,  1'b0, 4'd3, 9, {2'b00, 8'hFF, 8'h00}, "a_max_1");
        run_op(0, 8'd7,   8'd100, 1'b0, 4'd4, 9, {2'b00, 8'h00, 8'h07}, "a_small");
        run_op(0, 8'hFF,  8'hFF, 1'b0, 4'd5, 9, {2'b00, 8'h01, 8'h00}, "a_ff_ff");
`ifdef DIVIDER_SIGNED_EN
        run_op(0, 8'hF9,  8'd2,  1'b1, 4'd6, 9, {2'b00, 8'hFD, 8'hFF}, "a_neg7_2");
        run_op(0, 8'h80,  8'hFF, 1'b1, 4'd7, 9, {2'b01, 8'h80, 8'h00}, "a_min_m1");
`else
        run_op(0, 8'hF9,  8'd2,  1'b1, 4'd6, 9, {2'b00, 8'd124, 8'd1}, "a_neg7_2");
        run_op(0, 8'h80,  8'hFF, 1'b1, 4'd7, 9, {2'b00, 8'h00, 8'h80}, "a_min_m1");
`endif

        run_op(1, 8'd2,  8'd1, 1'b0, 4'd8, 9, {2'b01, 8'h00, 8'h00}, "b_ovf");
        run_op(1, 8'd1,  8'd3, 1'b0, 4'd9, 9, {2'b00, 8'h55, 8'h01}, "b_1_3");
        run_op(1, 8'd3,  8'd4, 1'b0, 4'hA, 9, {2'b00, 8'hC0, 8'h00}, "b_3_4");
        run_op(1, 8'h5A, 8'd0, 1'b0, 4'hB, 9, {2'b10, 8'hFF, 8'h5A}, "b_dbz");

        run_op(2, 8'd100, 8'd7, 1'b0, 4'hC, 0, {2'b00, 8'd14, 8'd2}, "c_100_7");
        run_op(2, 8'd200, 8'd3, 1'b0, 4'hD, 0, {2'b00, 8'd66, 8'd2}, "c_200_3");
        @(negedge clk);
        o_ready = 1'b0;
        iv[2]   = 1'b1;
        #1;
        check_eq("c_backpressure", ir[2], 0);
        iv[2] = 1'b0;

        // Stream: o_ready held low for 10 cycles, then mostly high.
        sent = 0; got = 0; acc = 1'b0; prev_ov = 1'b0; prev_ordy = 1'b1; prev_out = '0;
        for (int cyc = 0; cyc < 3000 && got < 50; cyc++) begin
            @(negedge clk);
            if (acc) begin
                iv[0] = 1'b0;
                acc   = 1'b0;
            end
            if (!iv[0] && sent < 50 && $urandom_range(0, 4) != 0) begin
                a_in  = 8'($urandom);
                b_in  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
                sgn   = 1'($urandom_range(0, 1));
                id_in = 4'(sent);
                iv[0] = 1'b1;
                sent++;
            end
            o_ready = (cyc < 10) ? 1'b0 : ($urandom_range(0, 3) != 0);
            #1;
            cur = {oid[0], dbz[0], ovf[0], q[0], r[0]};
            if (prev_ov && !prev_ordy) begin
                check_eq("hold", {ov[0], cur}, {1'b1, prev_out});
            end
            if (iv[0] && ir[0]) begin
                exp_q.push_back({id_in, ref_div(a_in, b_in, sgn)});
                acc = 1'b1;
            end
            if (ov[0] && o_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("stream_extra", cur, 22'h3FFFFF);
                end else begin
                    check_eq("stream", cur, exp_q.pop_front());
                end
                got++;
            end
            prev_ov   = ov[0];
            prev_ordy = o_ready;
            prev_out  = cur;
        end
        @(negedge clk);
        iv[0] = 1'b0;
        check_eq("stream_count", got, 50);
        check_eq("stream_left", exp_q.size(), 0);

        // Reset with three ops in flight.
        o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in  = 8'(50 + i);
            b_in  = 8'd3;
            sgn   = 1'b0;
            id_in = 4'(10 + i);
            iv[0] = 1'b1;
            @(negedge clk);
        end
        iv[0] = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        #1;
        check_eq("midrst_ovalid", ov[0], 0);
        check_eq("midrst_iready", ir[0], 1);
        rst = 1'b0;
        run_op(0, 8'd200, 8'd9, 1'b0, 4'd5, 9, {2'b00, 8'd22, 8'd2}, "post_rst");
        seen = 0;
        o_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (ov[0]) seen++;
        end
        check_eq("post_rst_drain", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
